// File: rtl/ir_pkg.sv
// Shared types, widths and NEC pulse-width windows (all in microseconds)
// for the IR decoder and its pulse timer.
package ir_pkg;
  localparam int BIT_CNT_W = 6;
  localparam int WIDTH_W   = 14;

  typedef logic [WIDTH_W-1:0] us_t;

  localparam us_t WIDTH_SAT   = '1;
  localparam us_t LEAD_LO_MIN = 14'd8000;
  localparam us_t LEAD_LO_MAX = 14'd10000;
  localparam us_t LEAD_HI_MIN = 14'd4000;
  localparam us_t LEAD_HI_MAX = 14'd5000;
  localparam us_t REP_HI_MIN  = 14'd2000;
  localparam us_t REP_HI_MAX  = 14'd2500;
  localparam us_t BIT_LO_MIN  = 14'd400;
  localparam us_t BIT_LO_MAX  = 14'd700;
  localparam us_t ZERO_MIN    = 14'd400;
  localparam us_t ZERO_MAX    = 14'd700;
  localparam us_t ONE_MIN     = 14'd1400;
  localparam us_t ONE_MAX     = 14'd1900;

  typedef enum logic [2:0] {
    IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP_LO, REP_LO
  } ir_state_t;

  // Inclusive window test.
  function automatic logic in_win(input us_t w, input us_t lo, input us_t hi);
    return (w >= lo) && (w <= hi);
  endfunction
endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes the raw IR input, detects edges and measures the time in
// microseconds since the previous edge (saturating).
import ir_pkg::*;

module ir_pulse_timer #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_rx,
  output logic rise,
  output logic fall,
  output logic tick_us,
  output us_t  width_us
);
  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_US - 1);

  logic [2:0]    sync;
  logic [PW-1:0] pre;

  assign tick_us = (pre == PRE_MAX);

  // Synchronizer resets to the idle-high level so reset never fakes a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 3'b111;
      rise     <= 1'b0;
      fall     <= 1'b0;
      pre      <= '0;
      width_us <= '0;
    end else begin
      sync <= {sync[1:0], ir_rx};
      rise <= sync[1] & ~sync[2];
      fall <= ~sync[1] & sync[2];
      pre  <= tick_us ? '0 : pre + 1'b1;
      // Cleared one cycle after the edge strobe so the consumer sees the
      // finished interval alongside rise/fall.
      if (rise || fall)
        width_us <= '0;
      else if (tick_us && width_us != WIDTH_SAT)
        width_us <= width_us + 1'b1;
    end
  end
endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: leader/bit/stop FSM, 32-bit shift register,
// inverse checks, repeat handling and the ir_ready hold timer.
import ir_pkg::*;

module nec_ir_decoder #(
  parameter int CLKS_PER_US    = 50,
  parameter int READY_MS       = 1100,
  parameter int CHECK_ADDR_INV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_rx,
  output logic [31:0] ir_data,
  output logic        ir_ready,
  output logic        ir_valid,
  output logic        ir_repeat,
  output logic        ir_err
);
  localparam int HW = $clog2(READY_MS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(READY_MS);

  logic rise, fall, tick_us;
  us_t  width_us;

  ir_pulse_timer #(.CLKS_PER_US(CLKS_PER_US)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ir_rx    (ir_rx),
    .rise     (rise),
    .fall     (fall),
    .tick_us  (tick_us),
    .width_us (width_us)
  );

  ir_state_t             state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [31:0]           shreg;
  logic                  seen;
  logic [HW-1:0]         hold;
  logic [9:0]            ms_cnt;

  logic sat, lo_ok, zero_ok, one_ok, lead_frame, lead_rep;
  logic cmd_ok, addr_ok, frame_ok, rep_ok, chk_fail, abort;

  always_comb begin
    sat        = (width_us == WIDTH_SAT);
    lo_ok      = in_win(width_us, BIT_LO_MIN, BIT_LO_MAX);
    zero_ok    = in_win(width_us, ZERO_MIN, ZERO_MAX);
    one_ok     = in_win(width_us, ONE_MIN, ONE_MAX);
    lead_frame = in_win(width_us, LEAD_HI_MIN, LEAD_HI_MAX);
    lead_rep   = in_win(width_us, REP_HI_MIN, REP_HI_MAX);
    cmd_ok     = ((shreg[23:16] ^ shreg[31:24]) == 8'hFF);
    addr_ok    = (CHECK_ADDR_INV == 0) || ((shreg[7:0] ^ shreg[15:8]) == 8'hFF);
    frame_ok   = (state == STOP_LO) && rise && lo_ok && cmd_ok && addr_ok;
    chk_fail   = (state == STOP_LO) && rise && lo_ok && !(cmd_ok && addr_ok);
    rep_ok     = (state == REP_LO) && rise && lo_ok && seen;
    // Window failures past the leader-low phase; saturation counts as one.
    abort = 1'b0;
    case (state)
      LEAD_HI: abort = sat || (fall && !lead_frame && !lead_rep);
      BIT_HI:  abort = sat || (fall && !zero_ok && !one_ok);
      BIT_LO, STOP_LO, REP_LO: abort = sat || (rise && !lo_ok);
      default: abort = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      seen      <= 1'b0;
      ir_data   <= '0;
      ir_valid  <= 1'b0;
      ir_repeat <= 1'b0;
      ir_err    <= 1'b0;
    end else begin
      ir_valid  <= frame_ok;
      ir_repeat <= rep_ok;
      ir_err    <= abort | chk_fail;
      if (frame_ok) begin
        ir_data <= shreg;
        seen    <= 1'b1;
      end
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (fall) state <= LEAD_LO;
          LEAD_LO: begin
            if (sat)
              state <= IDLE;
            else if (rise)
              state <= in_win(width_us, LEAD_LO_MIN, LEAD_LO_MAX) ? LEAD_HI : IDLE;
          end
          LEAD_HI: begin
            if (fall && lead_frame) begin
              state   <= BIT_LO;
              bit_cnt <= '0;
            end else if (fall) begin
              state <= REP_LO;
            end
          end
          BIT_LO:  if (rise) state <= BIT_HI;
          BIT_HI: begin
            if (fall) begin
              shreg[bit_cnt[4:0]] <= one_ok;
              bit_cnt <= bit_cnt + 1'b1;
              state   <= (bit_cnt == BIT_CNT_W'(31)) ? STOP_LO : BIT_LO;
            end
          end
          STOP_LO, REP_LO: if (rise) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Hold timer restarts its ms phase on load so the deadline is load + READY_MS.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      ms_cnt <= '0;
    end else if (frame_ok || rep_ok) begin
      hold   <= HOLD_LOAD;
      ms_cnt <= '0;
    end else if (tick_us) begin
      if (ms_cnt == 10'd999) begin
        ms_cnt <= '0;
        if (hold != '0) hold <= hold - 1'b1;
      end else begin
        ms_cnt <= ms_cnt + 1'b1;
      end
    end
  end

  assign ir_ready = (hold != '0);
endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder: frames, repeats, bad inverse, window
// violations, reset mid-frame and the ready hold time.
module tb_nec_ir_decoder;
  localparam int CPU = 1;
  localparam int RMS = 12;
  localparam int T_LL = 8100, T_LH = 4100, T_RH = 2100;
  localparam int T_LO = 410, T_ZERO = 410, T_ONE = 1410;
  localparam int HOLD_CYC = RMS * 1000 * CPU;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_rx = 1'b1;
  logic [31:0] ir_data;
  logic        ir_ready, ir_valid, ir_repeat, ir_err;

  always #5 clk = ~clk;

  nec_ir_decoder #(.CLKS_PER_US(CPU), .READY_MS(RMS), .CHECK_ADDR_INV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir_rx     (ir_rx),
    .ir_data   (ir_data),
    .ir_ready  (ir_ready),
    .ir_valid  (ir_valid),
    .ir_repeat (ir_repeat),
    .ir_err    (ir_err)
  );

  int total = 0, bad = 0;
  int cyc = 0, n_valid = 0, n_rep = 0, n_err = 0, n_rr = 0;
  int valid_cyc = 0, rep_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic ready_q = 1'b0;

  // Pulse and ready-edge bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (ir_valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
    if (ir_repeat === 1'b1) begin n_rep++; rep_cyc = cyc; end
    if (ir_err === 1'b1) n_err++;
    if (ir_ready === 1'b1 && ready_q !== 1'b1) begin n_rr++; rise_cyc = cyc; end
    if (ir_ready === 1'b0 && ready_q === 1'b1) fall_cyc = cyc;
    ready_q = ir_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_lvl(input logic lvl, input int us);
    ir_rx = lvl;
    repeat (us * CPU) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    hold_lvl(1'b0, T_LL);
    hold_lvl(1'b1, T_LH);
    for (int i = 0; i < nbits; i++) begin
      hold_lvl(1'b0, T_LO);
      hold_lvl(1'b1, w[i] ? T_ONE : T_ZERO);
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_bits(w, 32);
    hold_lvl(1'b0, T_LO);
    hold_lvl(1'b1, 200);
  endtask

  task automatic send_rep();
    hold_lvl(1'b0, T_LL);
    hold_lvl(1'b1, T_RH);
    hold_lvl(1'b0, T_LO);
    hold_lvl(1'b1, 200);
  endtask

  initial begin
    int dur;
    repeat (4) @(negedge clk);
    chk("rst_data", ir_data, 32'h0);
    chk("rst_ready", {31'b0, ir_ready}, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_repeat", {31'b0, ir_repeat}, 32'h0);
    chk("rst_err", {31'b0, ir_err}, 32'h0);
    rst = 1'b0;
    hold_lvl(1'b1, 50);

    // Repeat code before any frame: ignored silently.
    send_rep();
    chk("norep_rep", n_rep, 0);
    chk("norep_ready", {31'b0, ir_ready}, 32'h0);
    chk("norep_err", n_err, 0);

    // Short leader: silent drop.
    hold_lvl(1'b0, 7000);
    hold_lvl(1'b1, 1000);
    chk("short_lead_err", n_err, 0);
    chk("short_lead_valid", n_valid, 0);

    send_frame(32'hE916FF00);
    chk("f1_data", ir_data, 32'hE916FF00);
    chk("f1_valid", n_valid, 1);
    chk("f1_err", n_err, 0);
    chk("f1_ready", {31'b0, ir_ready}, 32'h1);
    chk("f1_ready_rise", rise_cyc, valid_cyc);

    send_rep();
    chk("rep_pulse", n_rep, 1);
    chk("rep_data", ir_data, 32'hE916FF00);
    chk("rep_ready", {31'b0, ir_ready}, 32'h1);

    // Command inverse wrong (16 ^ E8 = FE).
    send_frame(32'hE816FF00);
    chk("badinv_err", n_err, 1);
    chk("badinv_valid", n_valid, 1);
    chk("badinv_data", ir_data, 32'hE916FF00);
    dur = fall_cyc - rep_cyc;
    chk("rep_extends_ready", {31'b0, (dur >= HOLD_CYC - 1000 && dur <= HOLD_CYC + 1000)}, 32'h1);
    chk("ready_single_rise", n_rr, 1);

    // Reset during bit 20 low.
    send_bits(32'h0, 20);
    hold_lvl(1'b0, 200);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", ir_data, 32'h0);
    chk("mid_rst_ready", {31'b0, ir_ready}, 32'h0);
    chk("mid_rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("mid_rst_repeat", {31'b0, ir_repeat}, 32'h0);
    chk("mid_rst_err", {31'b0, ir_err}, 32'h0);
    rst = 1'b0;
    hold_lvl(1'b0, 200);
    hold_lvl(1'b1, 3000);
    chk("mid_rst_tail_silent", n_err, 1);

    // Bit 12 high of 1000 us falls between the zero and one windows.
    send_bits(32'h0, 12);
    hold_lvl(1'b0, T_LO);
    hold_lvl(1'b1, 1000);
    hold_lvl(1'b0, T_LO);
    hold_lvl(1'b1, 3000);
    chk("bitwin_err", n_err, 2);
    chk("bitwin_valid", n_valid, 1);

    send_frame(32'hC33CA55A);
    chk("f2_data", ir_data, 32'hC33CA55A);
    chk("f2_valid", n_valid, 2);
    chk("f2_err", n_err, 2);
    chk("f2_ready", {31'b0, ir_ready}, 32'h1);
    repeat (HOLD_CYC + 1000) @(negedge clk);
    chk("f2_ready_drop", {31'b0, ir_ready}, 32'h0);
    dur = fall_cyc - valid_cyc;
    chk("f2_hold_time", {31'b0, (dur >= HOLD_CYC - 1000 && dur <= HOLD_CYC + 1000)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
